countor_up: RTL and testbench

//   Modulo-N up counter with enable, synchronous clear/load, wrap pulse and sticky overflow flag.

---
 rtl/countor_up.sv | 81 ++++++++
 tb/tb_countor_up.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countor_up.sv
// Modulo-(MAX+1) up counter with enable, synchronous clear/load, a registered
// one-cycle wrap pulse (o_tc) and a sticky overflow flag (o_ovf).
// o_tc can drive the i_en of a further counter stage to cascade timebases.
module countor_up #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MAX   = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] W_MAX  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] W_ONE  = WIDTH'(1);
    localparam int unsigned      FULL   = (1 << WIDTH) - 1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_nxt;
    logic [WIDTH-1:0] w_load_clip;

    // Saturate out-of-range load values to MAX; when MAX is the all-ones value
    // every load value is already in range, so no comparator is built.
    generate
        if (MAX >= FULL) begin : g_no_clip
            assign w_load_clip = i_load_val;
        end else begin : g_clip
            assign w_load_clip = (i_load_val > W_MAX) ? W_MAX : i_load_val;
        end
    endgenerate

    // Next-state decode: clear beats load beats enable beats hold.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_ovf_nxt   = r_ovf;
        if (i_clr) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else if (i_load) begin
            w_count_nxt = w_load_clip;
        end else if (i_en) begin
            // >= rather than == so an out-of-range state still wraps
            if (r_count >= W_MAX) begin
                w_count_nxt = '0;
                w_tc_nxt    = 1'b1;
                w_ovf_nxt   = 1'b1;
            end else begin
                w_count_nxt = r_count + W_ONE;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign o_count = r_count;
    assign o_tc    = r_tc;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_countor_up.sv
// Self-checking bench for countor_up: a MAX=7 instance checked against a
// hand-written vector table, and a MAX=6 instance checked against a small
// behavioural model, both through expected-value queues, plus hand sequences
// for reset, saturating load and mid-count asynchronous reset.
module tb_countor_up;

    localparam int unsigned WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;

    logic [WIDTH-1:0] count7, count6;
    logic             tc7, tc6, ovf7, ovf6;

    always #5 clk = ~clk;

    countor_up #(.WIDTH(WIDTH), .MAX(7)) u_dut7 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_clr      (clr),
        .i_load     (load),
        .i_load_val (load_val),
        .o_count    (count7),
        .o_tc       (tc7),
        .o_ovf      (ovf7)
    );

    countor_up #(.WIDTH(WIDTH), .MAX(6)) u_dut6 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_clr      (clr),
        .i_load     (load),
        .i_load_val (load_val),
        .o_count    (count6),
        .o_tc       (tc6),
        .o_ovf      (ovf6)
    );

    typedef struct {
        logic             clr;
        logic             load;
        logic             en;
        logic [WIDTH-1:0] load_val;
        logic [WIDTH-1:0] e_count;
        logic             e_tc;
        logic             e_ovf;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t q7[$];
    exp_t q6[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state of the MAX=6 instance
    logic [WIDTH-1:0] m_count = '0;
    logic             m_tc    = 1'b0;
    logic             m_ovf   = 1'b0;

    task automatic check(input string name,
                         input logic [WIDTH-1:0] a_c, input logic a_tc, input logic a_ovf,
                         input logic [WIDTH-1:0] e_c, input logic e_tc, input logic e_ovf);
        n_cmp++;
        if (a_c !== e_c || a_tc !== e_tc || a_ovf !== e_ovf) begin
            n_bad++;
            $display("FAIL %s: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                     name, a_c, a_tc, a_ovf, e_c, e_tc, e_ovf);
        end
    endtask

    task automatic add_vec(input logic c, input logic l, input logic e, input int lv,
                           input int ec, input logic etc, input logic eovf);
        vec_t v;
        v.clr      = c;
        v.load     = l;
        v.en       = e;
        v.load_val = WIDTH'(lv);
        v.e_count  = WIDTH'(ec);
        v.e_tc     = etc;
        v.e_ovf    = eovf;
        vecs.push_back(v);
    endtask

    // Behavioural next state for MAX=6
    task automatic model6_step(input logic c, input logic l, input logic e,
                               input logic [WIDTH-1:0] lv);
        if (c) begin
            m_count = '0;
            m_tc    = 1'b0;
            m_ovf   = 1'b0;
        end else if (l) begin
            m_count = (lv > 3'd6) ? 3'd6 : lv;
            m_tc    = 1'b0;
        end else if (e) begin
            if (m_count >= 3'd6) begin
                m_count = '0;
                m_tc    = 1'b1;
                m_ovf   = 1'b1;
            end else begin
                m_count = m_count + 3'd1;
                m_tc    = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus and queue what each instance must show after the edge
    task automatic drive(input logic c, input logic l, input logic e, input logic [WIDTH-1:0] lv,
                         input logic [WIDTH-1:0] ec, input logic etc, input logic eovf);
        exp_t x;
        clr      = c;
        load     = l;
        en       = e;
        load_val = lv;
        x.count  = ec;
        x.tc     = etc;
        x.ovf    = eovf;
        q7.push_back(x);
        model6_step(c, l, e, lv);
        x.count = m_count;
        x.tc    = m_tc;
        x.ovf   = m_ovf;
        q6.push_back(x);
    endtask

    // Clock edge, then compare both instances against the queue heads
    task automatic tick(input string name);
        exp_t x;
        @(posedge clk);
        #1;
        if (q7.size() == 0 || q6.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got q7=%0d q6=%0d entries, want 1 each",
                     name, q7.size(), q6.size());
        end else begin
            x = q7.pop_front();
            check({name, "/max7"}, count7, tc7, ovf7, x.count, x.tc, x.ovf);
            x = q6.pop_front();
            check({name, "/max6"}, count6, tc6, ovf6, x.count, x.tc, x.ovf);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000, want finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held from t=0 with en high: outputs stay cleared across edges
        rst_n    = 1'b0;
        en       = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold/max7", count7, tc7, ovf7, 3'd0, 1'b0, 1'b0);
        check("reset_hold/max6", count6, tc6, ovf6, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #2;
        check("reset_release", count7, tc7, ovf7, 3'd0, 1'b0, 1'b0);

        // clr load en lv | count tc ovf  (MAX=7)
        for (int i = 1; i <= 7; i++) add_vec(0, 0, 1, 0, i, 0, 0);
        add_vec(0, 0, 1, 0, 0, 1, 1);   // wrap
        add_vec(0, 0, 1, 0, 1, 0, 1);   // tc drops, ovf sticks
        add_vec(0, 1, 1, 5, 5, 0, 1);   // load beats en
        add_vec(0, 0, 1, 0, 6, 0, 1);
        add_vec(0, 1, 0, 4, 4, 0, 1);
        add_vec(1, 1, 1, 2, 0, 0, 0);   // clr beats load and en
        add_vec(0, 1, 1, 7, 7, 0, 0);
        add_vec(0, 0, 1, 0, 0, 1, 1);
        add_vec(0, 0, 0, 0, 0, 0, 1);
        add_vec(0, 1, 0, 6, 6, 0, 1);
        add_vec(0, 0, 1, 0, 7, 0, 1);   // en toggling at the top
        add_vec(0, 0, 0, 0, 7, 0, 1);   // held at MAX, no tc
        add_vec(0, 0, 1, 0, 0, 1, 1);
        add_vec(0, 0, 0, 0, 0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0, 1);
        add_vec(1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].load_val,
                  vecs[i].e_count, vecs[i].e_tc, vecs[i].e_ovf);
            tick($sformatf("vec%0d", i));
        end

        // Saturating load on the MAX=6 instance, then wrap from MAX
        drive(0, 1, 0, 3'b111, 3'd7, 1'b0, 1'b0);
        tick("sat_load");
        check("sat_load_max6", count6, tc6, ovf6, 3'd6, 1'b0, 1'b0);
        drive(0, 0, 1, 3'd0, 3'd0, 1'b1, 1'b1);
        tick("sat_wrap");
        check("sat_wrap_max6", count6, tc6, ovf6, 3'd0, 1'b1, 1'b1);

        // Count to 3, then pulse reset between edges
        drive(1, 0, 0, 3'd0, 3'd0, 1'b0, 1'b0);
        tick("pre_clr");
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 1, 3'd0, WIDTH'(i), 1'b0, 1'b0);
            tick($sformatf("up%0d", i));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst/max7", count7, tc7, ovf7, 3'd0, 1'b0, 1'b0);
        check("async_rst/max6", count6, tc6, ovf6, 3'd0, 1'b0, 1'b0);
        m_count = '0;
        m_tc    = 1'b0;
        m_ovf   = 1'b0;
        @(posedge clk);
        #1;
        check("rst_low_edge", count7, tc7, ovf7, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(0, 0, 1, 3'd0, 3'd1, 1'b0, 1'b0);
        tick("resume1");
        drive(0, 0, 1, 3'd0, 3'd2, 1'b0, 1'b0);
        tick("resume2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
